// File: rtl/mem_responder.sv
// mem_responder -- word-wide data-memory responder with programmable wait states.
//
// Accepts one load/store request at a time, holds it for LATENCY wait cycles,
// then completes it with a one-cycle ack. Storage is split into one byte lane
// per write strobe, each with a registered read port.
//
// Optional feature (compile-time macro MEM_ERR_EN):
//   defined     -> misaligned or out-of-range addresses set err on the ack
//                  cycle; such writes are dropped and such reads return 0.
//   not defined -> err is tied to 0, low address bits are ignored and high
//                  address bits wrap modulo DEPTH.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   req    in   request valid, held with stable fields until ack
//   we     in   1 = write, 0 = read
//   addr   in   byte address (ADDR_W)
//   wdata  in   write data (DATA_W)
//   wstrb  in   byte enables for writes (DATA_W/8)
//   ack    out  one-cycle completion pulse
//   rdata  out  read data, nonzero only during a read ack
//   err    out  error flag, valid only during ack
//   busy   out  high while a request is being accepted or serviced
module mem_responder #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = 32,
  parameter int LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                we,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                ack,
  output logic [DATA_W-1:0]   rdata,
  output logic                err,
  output logic                busy
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_reg, state_next;
  logic [3:0] cnt_reg, cnt_next;

  // Latched copy of the request; the initiator's fields are not looked at
  // again once the request has been accepted.
  logic                we_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [BYTES-1:0]    wstrb_reg;

  logic                accept;
  logic                req_err;
  logic                do_write;
  logic [IDX_W-1:0]    rd_idx;
  logic [IDX_W-1:0]    wr_idx;
  logic [DATA_W-1:0]   ram_q;

  assign accept = (state_reg == IDLE) && req;

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req) begin
          cnt_next = 4'(LATENCY);
          if (LATENCY > 0) state_next = WAIT;
          else             state_next = RESP;
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) state_next = RESP;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request fields are pure datapath; they are only consumed outside IDLE,
  // which reset always forces, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg    <= we;
      addr_reg  <= addr;
      wdata_reg <= wdata;
      wstrb_reg <= wstrb;
    end
  end

  // ---------------------------------------------------------- error check
`ifdef MEM_ERR_EN
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BYTES - 1);
  localparam logic [ADDR_W:0]   LIMIT    = (ADDR_W + 1)'(DEPTH * BYTES);

  assign req_err = (|(addr_reg & OFF_MASK)) || ({1'b0, addr_reg} >= LIMIT);
`else
  assign req_err = 1'b0;
`endif

  // Bits of the address outside the word index (only consulted for errors).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{addr, addr_reg};

  // --------------------------------------------------------------- storage
  // The read port is clocked every cycle. In IDLE it is fed straight from the
  // incoming address so that a LATENCY=0 request has its data by the ack
  // cycle; afterwards it follows the latched index. Writes land on the edge
  // that ends RESP, so any later accept edge already sees the new contents.
  assign rd_idx   = (state_reg == IDLE) ? addr[OFF_W +: IDX_W]
                                        : addr_reg[OFF_W +: IDX_W];
  assign wr_idx   = addr_reg[OFF_W +: IDX_W];
  assign do_write = (state_reg == RESP) && we_reg && !req_err && !reset;

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      logic [7:0] lane_mem [DEPTH];
      logic [7:0] lane_q_reg;

      always_ff @(posedge clk) begin
        if (do_write && wstrb_reg[gi]) begin
          lane_mem[wr_idx] <= wdata_reg[gi*8 +: 8];
        end
        lane_q_reg <= lane_mem[rd_idx];
      end

      assign ram_q[gi*8 +: 8] = lane_q_reg;
    end
  endgenerate

  // --------------------------------------------------------------- outputs
  assign ack   = (state_reg == RESP);
  assign err   = ack && req_err;
  assign rdata = (ack && !we_reg && !req_err) ? ram_q : '0;

  // A request waiting in IDLE counts as accepted this cycle, which keeps busy
  // continuously high across back-to-back requests.
  assign busy  = (state_reg != IDLE) || (req && !reset);

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: two instances (LATENCY=2 and LATENCY=0).
// Driver pushes the expected response into a per-instance queue; a monitor
// pops and compares on every ack.
module tb_mem_responder;

  localparam int DW = 64;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [1:0]    req, we, ack, err, busy;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [7:0]    wstrb [2];
  logic [DW-1:0] rdata [2];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    int            acc;
  } sb_t;

  sb_t q0[$];
  sb_t q1[$];

  mem_responder #(.DATA_W(64), .DEPTH(256), .ADDR_W(32), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
    .wdata(wdata[0]), .wstrb(wstrb[0]), .ack(ack[0]), .rdata(rdata[0]),
    .err(err[0]), .busy(busy[0])
  );

  mem_responder #(.DATA_W(64), .DEPTH(256), .ADDR_W(32), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
    .wdata(wdata[1]), .wstrb(wstrb[1]), .ack(ack[1]), .rdata(rdata[1]),
    .err(err[1]), .busy(busy[1])
  );

  task automatic check(input string name, input int d,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    end
  endtask

  // ------------------------------------------------------------ monitor
  task automatic mon(input int d);
    sb_t e;
    int  lat;
    bit  empty;
    lat   = (d == 0) ? 2 : 0;
    empty = (d == 0) ? (q0.size() == 0) : (q1.size() == 0);
    if (empty) begin
      checks++;
      errors++;
      $display("FAIL unexpected_ack dut%0d: got ack at cycle %0d expected none", d, cyc);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      $display("txn dut%0d cyc %0d rdata %h err %b", d, cyc, rdata[d], err[d]);
      check("rdata",       d, rdata[d], e.rdata);
      check("err",         d, 64'(err[d]), 64'(e.err));
      check("latency",     d, 64'(cyc - e.acc), 64'(lat));
      check("busy_at_ack", d, 64'(busy[d]), 64'd1);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int d = 0; d < 2; d++) begin
        if (ack[d] === 1'b1) mon(d);
      end
    end
  end

  // ------------------------------------------------------------- driver
  task automatic do_req(input int d, input logic w, input logic [31:0] a,
                        input logic [63:0] wd, input logic [7:0] ws,
                        input logic [63:0] exp_rd, input logic exp_err);
    sb_t e;
    bit  got;
    @(posedge clk); #1;
    we[d] = w; addr[d] = a; wdata[d] = wd; wstrb[d] = ws; req[d] = 1'b1;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.acc   = cyc + 1;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ack[d] === 1'b1) got = 1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout dut%0d: got no ack expected ack for addr %h", d, a);
      if (d == 0) void'(q0.pop_back());
      else        void'(q1.pop_back());
    end
    @(posedge clk); #1;
    req[d] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------- main
  initial begin
    bit            flag;
    int            acks;
    int            e0;
    sb_t           e;
    logic [63:0]   exp_rd;
    logic          exp_err;

    reset = 1'b1;
    req = '0; we = '0;
    for (int d = 0; d < 2; d++) begin
      addr[d] = '0; wdata[d] = '0; wstrb[d] = '0;
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    check("reset_ack",   0, 64'(ack[0]),  64'd0);
    check("reset_busy",  0, 64'(busy[0]), 64'd0);
    check("reset_rdata", 0, rdata[0],     64'd0);
    check("reset_err",   0, 64'(err[0]),  64'd0);
    check("reset_ack",   1, 64'(ack[1]),  64'd0);

    // Idle quiet for 10 cycles
    flag = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack !== 2'b00 || busy !== 2'b00) flag = 1;
    end
    check("idle_quiet", 0, 64'(flag), 64'd0);

    // Full write then read, LATENCY=2
    do_req(0, 1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D, 8'hFF, 64'd0, 1'b0);
    do_req(0, 1'b0, 32'h10, 64'd0, 8'h00, 64'hDEADBEEF_CAFEF00D, 1'b0);

    // Partial write
    do_req(0, 1'b1, 32'h10, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'd0, 1'b0);
    do_req(0, 1'b1, 32'h10, 64'd0, 8'h0F, 64'd0, 1'b0);
    do_req(0, 1'b0, 32'h10, 64'd0, 8'h00, 64'hFFFFFFFF_00000000, 1'b0);

    // wstrb=0 write is a no-op that still acks
    do_req(0, 1'b1, 32'h10, 64'h55555555_55555555, 8'h00, 64'd0, 1'b0);
    do_req(0, 1'b0, 32'h10, 64'd0, 8'h00, 64'hFFFFFFFF_00000000, 1'b0);

    // Misaligned read: error with the feature, aliases word 0x10 without it
`ifdef MEM_ERR_EN
    do_req(0, 1'b0, 32'h13, 64'd0, 8'h00, 64'd0, 1'b1);
`else
    do_req(0, 1'b0, 32'h13, 64'd0, 8'h00, 64'hFFFFFFFF_00000000, 1'b0);
`endif

    // Reset during WAIT of a write: write dropped, no ack
    do_req(0, 1'b1, 32'h18, 64'h1234, 8'hFF, 64'd0, 1'b0);
    @(posedge clk); #1;
    we[0] = 1'b1; addr[0] = 32'h18; wdata[0] = 64'hAAAA_BBBB; wstrb[0] = 8'hFF;
    req[0] = 1'b1;
    @(posedge clk); #1;            // accept edge passed, now in WAIT
    reset = 1'b1; req[0] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midreset_ack",  0, 64'(ack[0]),  64'd0);
    check("midreset_busy", 0, 64'(busy[0]), 64'd0);
    flag = 0;
    repeat (5) begin
      @(negedge clk);
      if (ack[0] !== 1'b0) flag = 1;
    end
    check("midreset_no_ack", 0, 64'(flag), 64'd0);
    do_req(0, 1'b0, 32'h18, 64'd0, 8'h00, 64'h1234, 1'b0);

    // Wrap-around / out-of-range
    do_req(0, 1'b1, 32'h0, 64'h01234567_89ABCDEF, 8'hFF, 64'd0, 1'b0);
`ifdef MEM_ERR_EN
    do_req(0, 1'b1, 32'h800, 64'hFEDCBA98_76543210, 8'hFF, 64'd0, 1'b1);
    do_req(0, 1'b0, 32'h800, 64'd0, 8'h00, 64'd0, 1'b1);
    exp_rd = 64'h01234567_89ABCDEF;
`else
    do_req(0, 1'b1, 32'h800, 64'hFEDCBA98_76543210, 8'hFF, 64'd0, 1'b0);
    do_req(0, 1'b0, 32'h800, 64'd0, 8'h00, 64'hFEDCBA98_76543210, 1'b0);
    exp_rd = 64'hFEDCBA98_76543210;
`endif
    do_req(0, 1'b0, 32'h0, 64'd0, 8'h00, exp_rd, 1'b0);

    // LATENCY=0: preload, then 4 back-to-back reads with req held
    do_req(1, 1'b1, 32'h20, 64'h11223344_55667788, 8'hFF, 64'd0, 1'b0);
    @(posedge clk); #1;
    we[1] = 1'b0; addr[1] = 32'h20; wstrb[1] = 8'h00; req[1] = 1'b1;
    e0 = cyc + 1;
    exp_err = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e.rdata = 64'h11223344_55667788;
      e.err   = exp_err;
      e.acc   = e0 + 2 * i;
      q1.push_back(e);
    end
    acks = 0;
    flag = 0;
    for (int k = 0; k < 40 && acks < 4; k++) begin
      @(negedge clk);
      if (busy[1] !== 1'b1) flag = 1;
      if (ack[1] === 1'b1) acks++;
    end
    check("b2b_ack_count", 1, 64'(acks), 64'd4);
    check("b2b_busy_held", 1, 64'(flag), 64'd0);
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(negedge clk);
    check("b2b_busy_drop", 1, 64'(busy[1]), 64'd0);
    check("b2b_ack_drop",  1, 64'(ack[1]),  64'd0);

    repeat (3) @(negedge clk);
    check("sb_drained", 0, 64'(q0.size() + q1.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
